// File: rtl/branch_predictor.sv
// Decode-stage branch predictor: direct-mapped BTB with per-entry 2-bit
// saturating counters, trained by control-flow outcomes resolved in execute.
module branch_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int ENTRIES  = 16
) (
  input  logic                clk,
  input  logic                async_rst,
  input  logic [PC_WIDTH-1:0] PC_D,
  input  logic                is_branch_D,
  input  logic                update_valid_E,
  input  logic [PC_WIDTH-1:0] PC_E,
  input  logic                taken_E,
  input  logic [PC_WIDTH-1:0] target_E,
  input  logic                prediction_taken_E,
  input  logic [PC_WIDTH-1:0] predicted_PC_E,
  output logic                prediction_source_D,
  output logic [PC_WIDTH-1:0] predicted_PC_D,
  output logic                mispredict_E
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = PC_WIDTH - IDX - 2;

  logic                valid_q  [ENTRIES];
  logic [TAGW-1:0]     tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX-1:0]      idx_lk_s;
  logic [TAGW-1:0]     tag_lk_s;
  logic                hit_lk_s;
  logic [IDX-1:0]      idx_up_s;
  logic [TAGW-1:0]     tag_up_s;
  logic                hit_up_s;
  logic                write_en_s;
  logic [PC_WIDTH-1:0] target_d;
  logic [1:0]          ctr_d;
  logic                unused_s;

  function automatic logic [IDX-1:0] pc_index(input logic [PC_WIDTH-1:0] pc);
    return pc[IDX+1:2];
  endfunction

  function automatic logic [TAGW-1:0] pc_tag(input logic [PC_WIDTH-1:0] pc);
    return pc[PC_WIDTH-1:IDX+2];
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  // Instruction-alignment bits carry no index or tag information.
  assign unused_s = ^{PC_D[1:0], PC_E[1:0]};

  assign idx_lk_s = pc_index(PC_D);
  assign tag_lk_s = pc_tag(PC_D);
  assign hit_lk_s = valid_q[idx_lk_s] & (tag_q[idx_lk_s] == tag_lk_s);

  assign idx_up_s = pc_index(PC_E);
  assign tag_up_s = pc_tag(PC_E);
  assign hit_up_s = valid_q[idx_up_s] & (tag_q[idx_up_s] == tag_up_s);

  // Decode lookup reads only registered state, so a same-index update is not bypassed.
  always_comb begin
    prediction_source_D = 1'b0;
    predicted_PC_D      = '0;
    if (is_branch_D & hit_lk_s & ctr_q[idx_lk_s][1]) begin
      prediction_source_D = 1'b1;
      predicted_PC_D      = target_q[idx_lk_s];
    end else begin
      prediction_source_D = 1'b0;
      predicted_PC_D      = '0;
    end
  end

  // Next state of the single entry addressed by the resolving instruction.
  always_comb begin
    write_en_s = 1'b0;
    target_d   = target_q[idx_up_s];
    ctr_d      = ctr_q[idx_up_s];
    if (update_valid_E) begin
      if (hit_up_s) begin
        write_en_s = 1'b1;
        ctr_d      = ctr_step(ctr_q[idx_up_s], taken_E);
        target_d   = taken_E ? target_E : target_q[idx_up_s];
      end else if (taken_E) begin
        write_en_s = 1'b1;
        ctr_d      = 2'b10;
        target_d   = target_E;
      end else begin
        write_en_s = 1'b0;
      end
    end else begin
      write_en_s = 1'b0;
    end
  end

  // Table storage; a miss-allocate simply overwrites whatever aliased there.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (write_en_s) begin
      valid_q[idx_up_s]  <= 1'b1;
      tag_q[idx_up_s]    <= tag_up_s;
      target_q[idx_up_s] <= target_d;
      ctr_q[idx_up_s]    <= ctr_d;
    end
  end

  assign mispredict_E = update_valid_E &
                        ((prediction_taken_E != taken_E) |
                         (prediction_taken_E & taken_E & (predicted_PC_E != target_E)));

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Decode-stage branch predictor for the RV32I pipelined core. It combines a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. It looks up the PC of the instruction in decode and drives `predicted_PC_D` and `prediction_source_D` into the fetch stage, where they override the sequential PC. It is trained by resolved control-flow outcomes from execute and flags mispredictions for the hazard unit.

## Interface
- `PC_WIDTH`, 32, width of all PC/target buses.
- `ENTRIES`, 16, BTB depth; power of two, ≥2. `IDX = log2(ENTRIES)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `async_rst`  in  1  asynchronous, active-high reset.
- `PC_D`  in  `PC_WIDTH`  PC of the instruction currently in decode.
- `is_branch_D`  in  1  decode identified a branch/jal/jalr.
- `update_valid_E`  in  1  a control-flow instruction resolved in execute this cycle.
- `PC_E`  in  `PC_WIDTH`  PC of the resolving instruction.
- `taken_E`  in  1  actual outcome.
- `target_E`  in  `PC_WIDTH`  actual taken target (`ALU_result_E`).
- `prediction_taken_E`  in  1  `prediction_source_D` pipelined to E for this instruction.
- `predicted_PC_E`  in  `PC_WIDTH`  `predicted_PC_D` pipelined to E.
- `prediction_source_D`  out  1  1 = fetch must take `predicted_PC_D`.
- `predicted_PC_D`  out  `PC_WIDTH`  predicted target.
- `mispredict_E`  out  1  the resolved outcome disagrees with the prediction.

## Operation
- **Entry contents:** `valid`, `tag[PC_WIDTH-IDX-3:0]`, `target[PC_WIDTH-1:0]`, `ctr[1:0]`.
- **Index and tag:** index = `PC[IDX+1:2]`; tag = `PC[PC_WIDTH-1:IDX+2]`. `PC[1:0]` is ignored.
- **Lookup (combinational, D):**
  - `hit_D` = `valid[idx] & tag[idx]==tag(PC_D)`.
  - `prediction_source_D` = `is_branch_D & hit_D & ctr[idx][1]`.
  - `predicted_PC_D` = `target[idx]` when `prediction_source_D`, else `'0`.
- **Update (rising edge, when `update_valid_E`):** compute `hit_E` for `PC_E` the same way.
  - Hit, taken: `ctr` increments, saturating at 2'b11; `target` ← `target_E`.
  - Hit, not taken: `ctr` decrements, saturating at 2'b00; `target` is unchanged.
  - Miss, taken: allocate and overwrite any aliasing entry. Set `valid`=1, `tag`=tag(`PC_E`), `target`=`target_E`, `ctr`=2'b10.
  - Miss, not taken: no state change.
- **Mispredict (combinational, E):** `mispredict_E` = `update_valid_E & ((prediction_taken_E != taken_E) | (prediction_taken_E & taken_E & predicted_PC_E != target_E))`.
- Only one entry is written per cycle; entries other than the indexed one hold.

## Timing
- **Lookup latency:** 0 cycles. Outputs are combinational from `PC_D`, `is_branch_D` and table registers.
- **Update latency:** 1 cycle. A lookup in the cycle after the update edge sees the new state.
- **Same-cycle update and lookup, same index:** the lookup returns the pre-update state (read-before-write). There is no bypass.
- **Reset:**
  - Asserting `async_rst` takes effect immediately, including mid-cycle or mid-update. All `valid`=0, `ctr`=2'b01, `target`='0, `tag`='0.
  - While `PC_E`/`update_valid_E` inputs are held, `prediction_source_D`=0, `predicted_PC_D`='0 and `mispredict_E` follows its combinational equation.
  - No update is performed on an edge while `async_rst` is high.
- **Counter boundaries:** 2'b11 + taken stays 2'b11. 2'b00 + not-taken stays 2'b00.
- **Aliasing:** two PCs with the same index and different tags evict each other on a taken miss. A not-taken miss never evicts.
- Stalling and flushing are handled externally by gating `is_branch_D` / `update_valid_E`. The block has no enable.

## Test plan
All scenarios use `ENTRIES`=16. PC 0x40 maps to index 0, tag 1.

1. **Reset state:** pulse `async_rst`, then `PC_D`=0x40, `is_branch_D`=1 → `prediction_source_D`=0, `predicted_PC_D`=0. Repeat `async_rst` mid-cycle after training → outputs drop to 0 immediately, and the entry misses afterward.
2. **Allocate:** update `PC_E`=0x40, taken, `target_E`=0x100 → next cycle lookup 0x40 gives source=1, `predicted_PC_D`=0x100. With `is_branch_D`=0 → source=0.
3. **Hysteresis and saturation:**
   - From `ctr`=10, apply two not-taken updates → 01 then 00, source=0, target still 0x100.
   - One taken update → 01, source=0. A second taken update → 10, source=1.
   - Four more taken updates → `ctr` stays 11.
4. **Alias eviction:**
   - With 0x40 trained, lookup 0x80 (index 0, tag 2) → source=0.
   - A not-taken update for 0x80 → 0x40 still hits.
   - A taken update for 0x80 with target 0x200 → 0x80 predicts 0x200; 0x40 misses.
5. **Read-before-write:** with 0x40 at `ctr`=01, in the same cycle drive lookup 0x40 and a taken update for 0x40 → source=0 that cycle, source=1 the next cycle.
6. **Mispredict:**
   - `prediction_taken_E`=1, `taken_E`=0 → `mispredict_E`=1.
   - Both taken, `predicted_PC_E`=0x100, `target_E`=0x104 → 1.
   - Both taken, targets equal → 0.
   - Both not taken → 0.
   - `update_valid_E`=0 → 0.
